// File: rtl/leaf_spine_link.sv
// Leaf-side endpoint of a leaf<->spine link: round-robin TX onto the spine link,
// plus an RX FIFO that filters by group and delivers each flit to its local node.
module leaf_spine_link #(
  parameter logic [3:0] GROUP_ID   = 4'b0101,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DWIDTH-1:0]   node_tx_data,
  input  logic [3:0]            node_tx_valid,
  output logic [3:0]            node_tx_ready,
  output logic [DWIDTH-1:0]     to_spine_data,
  output logic                  to_spine_valid,
  input  logic                  spine_fifo_full,
  input  logic [DWIDTH-1:0]     from_spine_data,
  input  logic                  from_spine_valid,
  output logic [DWIDTH-1:0]     node_rx_data,
  output logic [3:0]            node_rx_valid,
  input  logic [3:0]            node_rx_ready,
  output logic [7:0]            rx_drop_cnt,
  output logic [7:0]            misroute_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    HEAD_IDLE,
    HEAD_DELIVER,
    HEAD_DISCARD
  } head_state_t;

  // ---------------------------------------------------------------- TX path
  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       grant_any;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_any     = 1'b0;
    grant_idx     = 2'd0;
    cand          = 2'd0;
    node_tx_ready = '0;
    if (!spine_fifo_full) begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_grant + 2'(k);
        if (!grant_any && node_tx_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) node_tx_ready[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_spine_valid <= 1'b0;
      to_spine_data  <= '0;
      last_grant     <= 2'd3;
    end else begin
      to_spine_valid <= grant_any;
      if (grant_any) begin
        to_spine_data <= node_tx_data[grant_idx*DWIDTH +: DWIDTH];
        last_grant    <= grant_idx;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DWIDTH-1:0] head;
  logic [1:0]        head_sel;
  head_state_t       head_state;
  logic              pop, push, drop, full;

  assign head         = mem[rd_ptr];
  assign head_sel     = head[11:10];
  assign node_rx_data = head;
  assign full         = (count == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign push         = from_spine_valid && (!full || pop);
  assign drop         = from_spine_valid && full && !pop;

  always_comb begin
    head_state = HEAD_IDLE;
    if (count != '0) head_state = (head[15:12] == GROUP_ID) ? HEAD_DELIVER : HEAD_DISCARD;
  end

  always_comb begin
    node_rx_valid = '0;
    pop           = 1'b0;
    case (head_state)
      HEAD_DELIVER: begin
        node_rx_valid[head_sel] = 1'b1;
        pop                     = node_rx_ready[head_sel];
      end
      HEAD_DISCARD: pop = 1'b1;
      default:      ;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count alone,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= from_spine_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_drop_cnt  <= '0;
      misroute_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (head_state == HEAD_DISCARD && misroute_cnt != 8'hFF)
        misroute_cnt <= misroute_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_leaf_spine_link.sv
// Self-checking bench for leaf_spine_link: arbiter vector table, directed RX
// sequences and a randomized mix, all scored against queue-based models.
module tb_leaf_spine_link;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] node_tx_data;
  logic [3:0]  node_tx_valid;
  logic [3:0]  node_tx_ready;
  logic [15:0] to_spine_data;
  logic        to_spine_valid;
  logic        spine_fifo_full;
  logic [15:0] from_spine_data;
  logic        from_spine_valid;
  logic [15:0] node_rx_data;
  logic [3:0]  node_rx_valid;
  logic [3:0]  node_rx_ready;
  logic [7:0]  rx_drop_cnt;
  logic [7:0]  misroute_cnt;

  always #5 clk = ~clk;

  leaf_spine_link #(.GROUP_ID(4'b0101), .DWIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .node_tx_data(node_tx_data), .node_tx_valid(node_tx_valid), .node_tx_ready(node_tx_ready),
    .to_spine_data(to_spine_data), .to_spine_valid(to_spine_valid),
    .spine_fifo_full(spine_fifo_full),
    .from_spine_data(from_spine_data), .from_spine_valid(from_spine_valid),
    .node_rx_data(node_rx_data), .node_rx_valid(node_rx_valid), .node_rx_ready(node_rx_ready),
    .rx_drop_cnt(rx_drop_cnt), .misroute_cnt(misroute_cnt)
  );

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic [3:0] exp_ready;
  } arb_vec_t;

  arb_vec_t    vecs [18];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  m_last;
  logic [15:0] tx_q [$];
  logic [15:0] rx_m [$];
  int          m_drop, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] rr(input logic [3:0] v, input logic [1:0] last, input logic full);
    logic [1:0] idx;
    rr = 4'b0000;
    if (!full) begin
      for (int k = 1; k <= 4; k++) begin
        idx = last + 2'(k);
        if (v[idx]) begin
          rr = 4'b0001 << idx;
          break;
        end
      end
    end
  endfunction

  // One clock cycle: score combinational outputs mid-cycle, update the models,
  // then score registered outputs just after the edge.
  task automatic step();
    logic [3:0]  g;
    logic [15:0] head, exp_data;
    logic [1:0]  sel;
    logic        nv;
    #4;
    g = rr(node_tx_valid, m_last, spine_fifo_full);
    check("tx_ready", {28'd0, node_tx_ready}, {28'd0, g});
    nv = |g;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        tx_q.push_back(node_tx_data[i*16 +: 16]);
        m_last = 2'(i);
      end
    end
    if (rx_m.size() > 0) begin
      head = rx_m[0];
      sel  = head[11:10];
      if (head[15:12] == 4'h5) begin
        check("rx_valid", {28'd0, node_rx_valid}, {28'd0, 4'b0001 << sel});
        check("rx_data", {16'd0, node_rx_data}, {16'd0, head});
        if (node_rx_ready[sel]) head = rx_m.pop_front();
      end else begin
        check("rx_valid_misroute", {28'd0, node_rx_valid}, 32'd0);
        head = rx_m.pop_front();
        if (m_mis < 255) m_mis++;
      end
    end else begin
      check("rx_valid_empty", {28'd0, node_rx_valid}, 32'd0);
    end
    if (from_spine_valid) begin
      if (rx_m.size() < 8) rx_m.push_back(from_spine_data);
      else if (m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
    check("to_spine_valid", {31'd0, to_spine_valid}, {31'd0, nv});
    if (nv && tx_q.size() > 0) begin
      exp_data = tx_q.pop_front();
      check("to_spine_data", {16'd0, to_spine_data}, {16'd0, exp_data});
    end
    check("rx_drop_cnt", {24'd0, rx_drop_cnt}, m_drop);
    check("misroute_cnt", {24'd0, misroute_cnt}, m_mis);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_last = 2'd3;
    m_drop = 0;
    m_mis  = 0;
    tx_q.delete();
    rx_m.delete();
    check("reset_to_spine_valid", {31'd0, to_spine_valid}, 32'd0);
    check("reset_to_spine_data", {16'd0, to_spine_data}, 32'd0);
    check("reset_drop_cnt", {24'd0, rx_drop_cnt}, 32'd0);
    check("reset_misroute_cnt", {24'd0, misroute_cnt}, 32'd0);
    check("reset_rx_valid", {28'd0, node_rx_valid}, 32'd0);
  endtask

  task automatic idle_inputs();
    node_tx_valid    = 4'b0000;
    spine_fifo_full  = 1'b0;
    from_spine_valid = 1'b0;
    from_spine_data  = 16'h0000;
    node_rx_ready    = 4'b1111;
  endtask

  task automatic rx_push(input logic [15:0] flit);
    from_spine_valid = 1'b1;
    from_spine_data  = flit;
    step();
    from_spine_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 1'b0, 4'b0001};  vecs[1]  = '{4'hF, 1'b0, 4'b0010};
    vecs[2]  = '{4'hF, 1'b0, 4'b0100};  vecs[3]  = '{4'hF, 1'b0, 4'b1000};
    vecs[4]  = '{4'hF, 1'b0, 4'b0001};  vecs[5]  = '{4'hF, 1'b0, 4'b0010};
    vecs[6]  = '{4'hF, 1'b0, 4'b0100};  vecs[7]  = '{4'hF, 1'b0, 4'b1000};
    vecs[8]  = '{4'hF, 1'b1, 4'b0000};  vecs[9]  = '{4'hF, 1'b1, 4'b0000};
    vecs[10] = '{4'hF, 1'b1, 4'b0000};  vecs[11] = '{4'hF, 1'b0, 4'b0001};
    vecs[12] = '{4'hA, 1'b0, 4'b0010};  vecs[13] = '{4'h9, 1'b0, 4'b1000};
    vecs[14] = '{4'h9, 1'b0, 4'b0001};  vecs[15] = '{4'h4, 1'b0, 4'b0100};
    vecs[16] = '{4'h4, 1'b0, 4'b0100};  vecs[17] = '{4'h0, 1'b0, 4'b0000};

    reset        = 1'b1;
    node_tx_data = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single requester on node 2, one-cycle TX latency.
    node_tx_data[32 +: 16] = 16'h5A01;
    node_tx_valid = 4'b0100;
    #2;
    check("single_ready", {28'd0, node_tx_ready}, 32'h4);
    step();
    check("single_data", {16'd0, to_spine_data}, 32'h5A01);
    node_tx_valid = 4'b0000;
    step();

    // Arbiter vector table from a fresh reset.
    do_reset();
    for (int r = 0; r < 18; r++) begin
      for (int i = 0; i < 4; i++) node_tx_data[i*16 +: 16] = 16'(16'h1000 * (i + 1) + r);
      node_tx_valid   = vecs[r].valid;
      spine_fifo_full = vecs[r].full;
      #2;
      check("arb_vec_ready", {28'd0, node_tx_ready}, {28'd0, vecs[r].exp_ready});
      step();
    end
    idle_inputs();
    step();

    // RX delivery to two different nodes on consecutive cycles.
    rx_push(16'h5400);
    rx_push(16'h5C33);
    step();
    step();

    // Misrouted flit followed by a good one.
    rx_push(16'h6000);
    rx_push(16'h5000);
    step();
    step();
    check("plan_misroute_one", {24'd0, misroute_cnt}, 32'd1);

    // Overfill with no consumers, then push+pop while full.
    node_rx_ready = 4'b0000;
    for (int i = 0; i < 10; i++) rx_push(16'h5000 | (16'(i % 4) << 10) | 16'(i));
    check("plan_drop_two", {24'd0, rx_drop_cnt}, 32'd2);
    node_rx_ready = 4'b1110;
    step();
    node_rx_ready = 4'b1111;
    rx_push(16'h5111);
    check("full_push_pop_no_drop", {24'd0, rx_drop_cnt}, 32'd2);
    repeat (10) step();

    // Back-to-back misrouted flits are discarded one per cycle.
    for (int i = 0; i < 5; i++) rx_push(16'h6800 | 16'(i));
    repeat (3) step();

    // Reset in the middle of TX and RX traffic.
    node_tx_valid = 4'b1111;
    node_rx_ready = 4'b0000;
    for (int i = 0; i < 3; i++) rx_push(16'h5400 | 16'(i));
    from_spine_valid = 1'b1;
    do_reset();
    idle_inputs();
    step();
    step();

    // Counter saturation.
    node_rx_ready = 4'b0000;
    from_spine_valid = 1'b1;
    from_spine_data  = 16'h5000;
    repeat (265) step();
    check("drop_saturated", {24'd0, rx_drop_cnt}, 32'd255);
    from_spine_valid = 1'b0;
    node_rx_ready = 4'b1111;
    repeat (9) step();
    from_spine_valid = 1'b1;
    from_spine_data  = 16'h7123;
    repeat (262) step();
    check("misroute_saturated", {24'd0, misroute_cnt}, 32'd255);
    idle_inputs();
    step();

    // Randomized mix.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) node_tx_data[i*16 +: 16] = 16'($urandom);
      node_tx_valid    = 4'($urandom);
      spine_fifo_full  = ($urandom_range(0, 3) == 0);
      node_rx_ready    = 4'($urandom);
      from_spine_valid = $urandom_range(0, 1) == 1;
      from_spine_data  = {($urandom_range(0, 3) == 0) ? 4'h6 : 4'h5, 12'($urandom)};
      step();
    end
    idle_inputs();
    repeat (12) step();
    check("rx_model_drained", rx_m.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_spine_link.md
Name: leaf_spine_link

Overview:
- Leaf-side endpoint of one leaf<->spine link in a group; the opposite end of a spine router's leaf port.
- TX path: round-robin arbitration among 4 local node sources, registered onto the spine-bound link, throttled by the spine input-FIFO-full flag.
- RX path: buffers spine-bound-down flits in a FIFO, checks group, and delivers each flit to the local node named in its header.
- Single-flit packets. Flit header: [15:12] dest group, [11:10] dest node, [9:0] payload.

Parameters:
GROUP_ID, 4'b0101, group this leaf belongs to; RX flits with another group are discarded
DWIDTH, 16, flit width; header fields fixed at bits [15:10], so DWIDTH must be >= 16
FIFO_DEPTH, 8, RX FIFO entries; power of two, >= 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
node_tx_data  input  4*DWIDTH  node i flit at [i*DWIDTH +: DWIDTH]
node_tx_valid  input  4  node i has a flit
node_tx_ready  output  4  combinational one-hot grant; flit transfers when valid&ready
to_spine_data  output  DWIDTH  registered flit toward spine
to_spine_valid  output  1  one-cycle pulse per flit
spine_fifo_full  input  1  spine port input FIFO full; blocks new grants
from_spine_data  input  DWIDTH  flit from spine
from_spine_valid  input  1  one-cycle pulse per flit
node_rx_data  output  DWIDTH  RX FIFO head flit, shared by all nodes
node_rx_valid  output  4  one-hot, selected by head[11:10]; 0 when FIFO empty or head misrouted
node_rx_ready  input  4  node i accepts the flit
rx_drop_cnt  output  8  saturating count of flits dropped because the RX FIFO was full
misroute_cnt  output  8  saturating count of flits discarded for group mismatch

Behaviour:
Reset, synchronous, has priority over all other activity:
- to_spine_valid=0, to_spine_data=0, FIFO emptied, both counters=0.
- RR pointer set so node 0 has highest priority (last_grant=3).
- Reset mid-transfer discards the in-flight register and all FIFO contents.

TX arbiter:
- Grant is combinational.
- If spine_fifo_full=0 and any node_tx_valid is set, grant the first requester searching from (last_grant+1) mod 4 upward. node_tx_ready = one-hot of that grant.
- If spine_fifo_full=1, node_tx_ready=0.
- On a grant, next edge: to_spine_data <= granted flit, to_spine_valid <= 1, last_grant <= granted index. Latency is 1 cycle.
- Otherwise, next edge: to_spine_valid <= 0; to_spine_data holds its last value.
- Back-to-back grants are allowed, giving 1 flit/cycle peak. A single requester is granted every cycle.
- Rising spine_fifo_full blocks the grant in that same cycle. A flit already registered still goes out.

RX FIFO:
- Circular buffer with wr_ptr, rd_ptr and count (width clog2(FIFO_DEPTH)+1).
- Push when from_spine_valid=1.
- Pop when the head is delivered (node_rx_valid[sel] & node_rx_ready[sel]), or when the head is misrouted.
- When full:
  - Push and pop in the same cycle: the push is accepted and count is unchanged.
  - Push without pop: the flit is dropped and rx_drop_cnt increments, saturating at 255.
- Push into an empty FIFO: the flit is visible at the head the next cycle. RX latency is 1 cycle minimum.
- Pointers wrap modulo FIFO_DEPTH.

RX head FSM, states IDLE / DELIVER / DISCARD, evaluated combinationally on the head entry:
- IDLE: count=0; all node_rx_valid=0.
- DELIVER: count>0 and head[15:12]==GROUP_ID.
  - node_rx_valid[head[11:10]]=1, all other bits 0.
  - Pop on ready.
  - Head-of-line blocking is intended: other heads wait.
  - node_rx_ready bits for unselected nodes are ignored.
- DISCARD: count>0 and head group != GROUP_ID.
  - node_rx_valid=0.
  - Head is popped this cycle; misroute_cnt increments, saturating at 255.
  - Consecutive misrouted flits are discarded at one per cycle.
- Simultaneous push into an empty FIFO and pop: impossible, because pop requires count>0.

Test Plan:
- Reset, then node 2 only valid with flit 0x5A01 -> node_tx_ready=4'b0100 the same cycle; to_spine_data=0x5A01 and to_spine_valid=1 one cycle later.
- All 4 nodes valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; to_spine_valid high for 8 consecutive cycles.
- All nodes valid, spine_fifo_full=1 for 3 cycles -> node_tx_ready=0 and to_spine_valid=0 during the stall window; after release, arbitration resumes from the node after the last grant.
- RX flits 0x5400 (node 1) and 0x5C33 (node 3), node_rx_ready=4'b1111 -> node_rx_valid=4'b0010 with data 0x5400, then 4'b1000 with data 0x5C33 on consecutive cycles.
- RX flit 0x6000 (group 6), then 0x5000 -> first flit discarded, misroute_cnt=1; node_rx_valid=4'b0001 for the second flit.
- node_rx_ready=0, push 10 flits with GROUP_ID=5, FIFO_DEPTH=8 -> count=8, rx_drop_cnt=2; FIFO then drains its 8 flits in order. Push and pop in the same cycle while full -> accepted, no drop.
